// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO, any depth >= 2, active-low full/empty flags.
// Latency: a write is visible on dout_o one edge later; a pop shows the next head right after the edge.
// Backpressure: enqueue while full is dropped unless paired with a dequeue; dequeue while empty is ignored.
// Optional SYNC_FIFO_COUNT_EN adds the count_o occupancy output.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              enq_i,
    input  logic                              deq_i,
    input  logic [DATA_WIDTH-1:0]             din_i,
    output logic [DATA_WIDTH-1:0]             dout_o,
    output logic                              full_o_n,
`ifdef SYNC_FIFO_COUNT_EN
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
`endif
    output logic                              empty_o_n
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic enq_ok;
    logic deq_ok;

    // A full FIFO still takes a write when the same edge frees a slot.
    assign enq_ok = enq_i & ((count_q != FULL_CNT) | deq_i);
    assign deq_ok = deq_i & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (deq_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (enq_ok && !deq_ok) begin
            count_d = count_q + 1'b1;
        end else if (deq_ok && !enq_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk_i) begin
        if (enq_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o    = mem_q[rd_ptr_q];
    assign full_o_n  = (count_q != FULL_CNT);
    assign empty_o_n = (count_q != '0);

`ifdef SYNC_FIFO_COUNT_EN
    assign count_o = count_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: a 50x104 instance for reset/fill/drain/simultaneous/underflow, a 5x8 instance for wrap.
module tb_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         enq_a, deq_a;
    logic [103:0] din_a, dout_a;
    logic         full_n_a, empty_n_a;
    logic         enq_b, deq_b;
    logic [7:0]   din_b, dout_b;
    logic         full_n_b, empty_n_b;
`ifdef SYNC_FIFO_COUNT_EN
    logic [5:0]   count_a;
    logic [2:0]   count_b;
`endif

    sync_fifo #(.DATA_WIDTH(104), .FIFO_DEPTH(50)) u_fifo_a (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .enq_i     (enq_a),
        .deq_i     (deq_a),
        .din_i     (din_a),
        .dout_o    (dout_a),
        .full_o_n  (full_n_a),
`ifdef SYNC_FIFO_COUNT_EN
        .count_o   (count_a),
`endif
        .empty_o_n (empty_n_a)
    );

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) u_fifo_b (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .enq_i     (enq_b),
        .deq_i     (deq_b),
        .din_i     (din_b),
        .dout_o    (dout_b),
        .full_o_n  (full_n_b),
`ifdef SYNC_FIFO_COUNT_EN
        .count_o   (count_b),
`endif
        .empty_o_n (empty_n_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1ns later, where outputs are sampled and inputs changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_a = 1'b0; deq_a = 1'b0;
        enq_b = 1'b0; deq_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        din_a = '0; din_b = '0;
        idle();
        repeat (2) step();
        check("rst_empty_a", 128'(empty_n_a), 128'(0));
        check("rst_full_a",  128'(full_n_a),  128'(1));
        check("rst_empty_b", 128'(empty_n_b), 128'(0));
        check("rst_full_b",  128'(full_n_b),  128'(1));
`ifdef SYNC_FIFO_COUNT_EN
        check("rst_count_a", 128'(count_a), 128'(0));
`endif
        rst_n = 1'b1;
        step();

        // Three enqueues, then an asynchronous reset mid-cycle.
        for (int i = 1; i <= 3; i++) begin
            enq_a = 1'b1; din_a = 104'(i);
            step();
        end
        idle();
        check("pre_rst_head", 128'(dout_a), 128'(1));
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_empty", 128'(empty_n_a), 128'(0));
        check("async_rst_full",  128'(full_n_a),  128'(1));
        #1 rst_n = 1'b1;
        enq_a = 1'b1; din_a = 104'h A5;
        step();
        idle();
        check("post_rst_empty", 128'(empty_n_a), 128'(1));
        check("post_rst_dout",  128'(dout_a),    128'h A5);
        deq_a = 1'b1;
        step();
        idle();
        check("post_rst_drain", 128'(empty_n_a), 128'(0));

        // Fill 1..50, drop a 51st write, drain in order.
        for (int i = 1; i <= 50; i++) begin
            enq_a = 1'b1; din_a = 104'(i);
            step();
            if (i == 49) check("fill49_full", 128'(full_n_a), 128'(1));
        end
        check("fill50_full", 128'(full_n_a), 128'(0));
        din_a = 104'd99;
        step();
        idle();
        check("overflow_full", 128'(full_n_a), 128'(0));
        check("overflow_head", 128'(dout_a),   128'(1));
`ifdef SYNC_FIFO_COUNT_EN
        check("overflow_count", 128'(count_a), 128'(50));
`endif
        for (int i = 1; i <= 50; i++) begin
            check($sformatf("drain_%0d", i), 128'(dout_a), 128'(i));
            deq_a = 1'b1;
            step();
            if (i == 1) check("drain1_full", 128'(full_n_a), 128'(1));
        end
        idle();
        check("drained_empty", 128'(empty_n_a), 128'(0));

        // Simultaneous enq/deq while full.
        for (int i = 1; i <= 50; i++) begin
            enq_a = 1'b1; din_a = 104'(i);
            step();
        end
        enq_a = 1'b1; deq_a = 1'b1; din_a = 104'd77;
        step();
        idle();
        check("simfull_full", 128'(full_n_a), 128'(0));
        check("simfull_head", 128'(dout_a),   128'(2));
        for (int i = 2; i <= 50; i++) begin
            check($sformatf("simfull_rd_%0d", i), 128'(dout_a), 128'(i));
            deq_a = 1'b1;
            step();
        end
        idle();
        check("simfull_last", 128'(dout_a),    128'(77));
        check("simfull_one",  128'(empty_n_a), 128'(1));
        deq_a = 1'b1;
        step();
        idle();
        check("simfull_empty", 128'(empty_n_a), 128'(0));

        // Simultaneous enq/deq while empty: only the write is taken.
        enq_a = 1'b1; deq_a = 1'b1; din_a = 104'd5;
        step();
        idle();
        check("simempty_empty", 128'(empty_n_a), 128'(1));
        check("simempty_dout",  128'(dout_a),    128'(5));
        deq_a = 1'b1;
        step();
        idle();
        check("simempty_drain", 128'(empty_n_a), 128'(0));

        // Underflow.
        for (int i = 0; i < 3; i++) begin
            deq_a = 1'b1;
            step();
            check($sformatf("uflow_empty_%0d", i), 128'(empty_n_a), 128'(0));
            check($sformatf("uflow_full_%0d", i),  128'(full_n_a),  128'(1));
        end
        idle();
        enq_a = 1'b1; din_a = 104'd9;
        step();
        idle();
        check("uflow_enq_dout",  128'(dout_a),    128'(9));
        check("uflow_enq_empty", 128'(empty_n_a), 128'(1));

        // Recycle pattern on the depth-5 instance across several wraps.
        for (int i = 0; i < 5; i++) begin
            enq_b = 1'b1; din_b = 8'(10 + i);
            step();
        end
        idle();
        check("wrap_full", 128'(full_n_b), 128'(0));
        for (int k = 0; k < 12; k++) begin
            check($sformatf("wrap_rd_%0d", k), 128'(dout_b), 128'(10 + (k % 5)));
            enq_b = 1'b1; deq_b = 1'b1; din_b = 8'(10 + (k % 5));
            step();
            check($sformatf("wrap_full_%0d", k), 128'(full_n_b), 128'(0));
`ifdef SYNC_FIFO_COUNT_EN
            check($sformatf("wrap_count_%0d", k), 128'(count_b), 128'(5));
`endif
        end
        idle();
        check("wrap_head_end", 128'(dout_b), 128'(12));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, first-word-fall-through FIFO with parameterized width and arbitrary (non-power-of-two) depth.
- Serves as the storage queue inside the word-detect recycler, which loads one feature-map column per entry and re-enqueues dequeued columns to cycle a frame repeatedly.
- Status flags are active-low.

Parameters:
- DATA_WIDTH, 8: bits per entry.
- FIFO_DEPTH, 8: number of entries. Any integer ≥ 2; need not be a power of two (recycler uses 50).

Ports:
- clk_i, input, 1: clock; all state updates on rising edge.
- rst_n_i, input, 1: asynchronous active-low reset.
- enq_i, input, 1: enqueue request; writes din_i at the clock edge when accepted.
- deq_i, input, 1: dequeue request; pops the head entry at the clock edge when accepted.
- din_i, input, DATA_WIDTH: write data.
- dout_o, output, DATA_WIDTH: current head entry, combinational from storage.
- full_o_n, output, 1: 0 when the FIFO holds FIFO_DEPTH entries, else 1.
- empty_o_n, output, 1: 0 when the FIFO holds 0 entries, else 1.

Behaviour:
- State:
  - write pointer and read pointer, each $clog2(FIFO_DEPTH) bits;
  - occupancy count, $clog2(FIFO_DEPTH+1) bits;
  - storage array of FIFO_DEPTH x DATA_WIDTH.
- Reset: rst_n_i low clears both pointers and the count immediately, without waiting for a clock edge. Storage is not reset.
  - After reset: empty_o_n=0, full_o_n=1, dout_o = storage[0] (undefined content).
- Reset mid-operation discards all contents. The first enqueue after release writes to entry 0.
- Acceptance, decided from the registered count before the edge:
  - enq_ok = enq_i & (count != FIFO_DEPTH | deq_i);
  - deq_ok = deq_i & (count != 0).
- On an accepted enqueue, din_i is written to storage[wr_ptr] and wr_ptr advances.
- On an accepted dequeue, rd_ptr advances.
- Pointer advance: pointer + 1, wrapping from FIFO_DEPTH-1 to 0. Explicit compare, not modulo-2^n.
- Count update: +1 on enq_ok only, −1 on deq_ok only, unchanged when both or neither are accepted.
- Simultaneous enq and deq:
  - When full: both are accepted; the count stays at FIFO_DEPTH.
  - When empty: only the enqueue is accepted; the count becomes 1.
  - Otherwise: both are accepted; the count is unchanged.
- Overflow: enq_i while full without deq_i is silently dropped; no state changes.
- Underflow: deq_i while empty is ignored; pointers and count are unchanged.
- dout_o = storage[rd_ptr] combinationally.
  - Valid whenever empty_o_n=1.
  - Data enqueued at edge N is visible on dout_o after edge N when the FIFO was empty (one-cycle write-to-read latency).
  - After an accepted deq, dout_o shows the next entry in the same cycle the pointer updates.
- full_o_n and empty_o_n are derived combinationally from the count register. They change only after clock edges or reset.
- Ordering: strict FIFO order is preserved across any number of pointer wraps.

Optional Feature:
- Macro: SYNC_FIFO_COUNT_EN.
- When defined: adds output port count_o, width $clog2(FIFO_DEPTH+1), equal to the occupancy count register. It reads 0 in reset.
- When undefined: the port does not exist. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n_i=0 asynchronously mid-cycle after 3 enqueues -> empty_o_n=0 and full_o_n=1 immediately; the next enq of 0xA5 appears on dout_o after one edge.
- Fill/drain, DEPTH=50, WIDTH=104: enqueue values 1..50 -> full_o_n=0 after the 50th edge; a 51st enq of 99 is dropped; dequeue 50 times -> dout_o reads 1..50 in order, then empty_o_n=0.
- Simultaneous full: FIFO full with 1..50, enq=deq=1 with din=77 -> count stays 50, dout_o=2; after 49 more deqs the last entry read is 77.
- Simultaneous empty: empty FIFO, enq=deq=1 with din=5 -> empty_o_n=1 and dout_o=5 next cycle; the dequeue was ignored.
- Underflow: deq_i=1 for 3 cycles on empty -> flags unchanged; a following enq of 9 reads back 9.
- Wrap, recycle pattern: DEPTH=5, preload 10..14, then 12 cycles of deq with re-enqueue of dout_o -> dout_o sequence 10,11,12,13,14,10,11,..., count constant at 5.
